// File: rtl/uart_rx_word_ctrl.sv
// Gathers uart_rx bytes into BYTES_PER_WORD-byte words (first byte in the LSB lane)
// and offers each word on a valid/ready handshake. Partial words are dropped after an inter-byte timeout.
module uart_rx_word_ctrl #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CLKS   = 104160,
  parameter int CNT_W          = 18
) (
  input  logic                        i_Clock,
  input  logic                        reset,
  input  logic                        enable,
  output logic                        o_receive,
  input  logic                        i_Rx_DV,
  input  logic [7:0]                  i_Rx_Byte,
  output logic [8*BYTES_PER_WORD-1:0] o_Word,
  output logic                        o_Word_Valid,
  input  logic                        i_Word_Ready,
  output logic [3:0]                  o_Byte_Count,
  output logic                        o_Timeout,
  output logic                        o_Drop
);

  localparam int               WORD_W    = 8 * BYTES_PER_WORD;
  localparam logic [3:0]       LAST_LANE = 4'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        count_q, count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, receive_q, timeout_q, timeout_d, drop_q, drop_d;

  // Next-state logic: byte lane writes, timeout tracking and handshake sequencing.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drop_d = i_Rx_DV;
        if (enable) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          // Leaving COLLECT abandons the partial word without a timeout pulse.
          state_d = ST_IDLE;
          count_d = 4'd0;
          cnt_d   = '0;
        end else if (i_Rx_DV) begin
          for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (count_q == 4'(k)) begin
              word_d[8*k +: 8] = i_Rx_Byte;
            end else begin
              word_d[8*k +: 8] = word_q[8*k +: 8];
            end
          end
          cnt_d = '0;
          if (count_q == LAST_LANE) begin
            count_d = 4'd0;
            state_d = ST_HOLD;
          end else begin
            count_d = count_q + 4'd1;
          end
        end else if (count_q == 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          count_d   = 4'd0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        drop_d = i_Rx_DV;
        if (i_Word_Ready) begin
          state_d = enable ? ST_COLLECT : ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; valid and receive follow the next state so they are registered.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      count_q   <= 4'd0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      receive_q <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      valid_q   <= (state_d == ST_HOLD);
      receive_q <= (state_d == ST_COLLECT);
      timeout_q <= timeout_d;
      drop_q    <= drop_d;
    end
  end

  assign o_receive    = receive_q;
  assign o_Word       = word_q;
  assign o_Word_Valid = valid_q;
  assign o_Byte_Count = count_q;
  assign o_Timeout    = timeout_q;
  assign o_Drop       = drop_q;

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// Directed bench for uart_rx_word_ctrl: per-cycle vector table plus hand-written
// sequences for spacing, hold, timeout, terminal-cycle byte and reset in HOLD.
module tb_uart_rx_word_ctrl;

  logic        i_Clock = 1'b0;
  logic        reset, enable, i_Rx_DV, i_Word_Ready;
  logic [7:0]  i_Rx_Byte;
  logic        o_receive, o_Word_Valid, o_Timeout, o_Drop;
  logic [31:0] o_Word;
  logic [3:0]  o_Byte_Count;

  int checks   = 0;
  int failures = 0;

  uart_rx_word_ctrl #(
    .BYTES_PER_WORD(4),
    .TIMEOUT_CLKS  (100),
    .CNT_W         (7)
  ) dut (
    .i_Clock     (i_Clock),
    .reset       (reset),
    .enable      (enable),
    .o_receive   (o_receive),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Word      (o_Word),
    .o_Word_Valid(o_Word_Valid),
    .i_Word_Ready(i_Word_Ready),
    .o_Byte_Count(o_Byte_Count),
    .o_Timeout   (o_Timeout),
    .o_Drop      (o_Drop)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic        rst, en, dv;
    logic [7:0]  b;
    logic        rdy;
    logic        e_recv, e_valid;
    logic [3:0]  e_cnt;
    logic        e_to, e_drop, chk_w;
    logic [31:0] e_word;
  } vec_t;

  vec_t vecs[23];

  task automatic expect_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, advance one clock, sample 1 time unit later.
  task automatic cyc(input logic rst, input logic en, input logic dv, input logic [7:0] b, input logic rdy);
    reset = rst; enable = en; i_Rx_DV = dv; i_Rx_Byte = b; i_Word_Ready = rdy;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic check_outs(input string nm, input logic recv, input logic valid, input logic [3:0] cnt,
                            input logic to, input logic drop);
    expect_v({nm, ".receive"}, {31'd0, o_receive}, {31'd0, recv});
    expect_v({nm, ".valid"}, {31'd0, o_Word_Valid}, {31'd0, valid});
    expect_v({nm, ".count"}, {28'd0, o_Byte_Count}, {28'd0, cnt});
    expect_v({nm, ".timeout"}, {31'd0, o_Timeout}, {31'd0, to});
    expect_v({nm, ".drop"}, {31'd0, o_Drop}, {31'd0, drop});
  endtask

  task automatic feed_word(input string nm, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      cyc(1'b0, 1'b1, 1'b1, tmp[7:0], 1'b0);
    end
    check_outs(nm, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_v({nm, ".word"}, o_Word, w);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Word_Ready = 1'b0;

    //          rst   en    dv    byte   rdy   recv  valid cnt   to    drop  chkw  word
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0011};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 32'h0000_2211};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h4433_2211};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h4433_2211};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 32'h4433_2211};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 32'h4433_2211};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 32'h4433_22AA};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h8877_6655};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h8877_6655};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

    #2;
    for (int v = 0; v < 23; v++) begin
      cyc(vecs[v].rst, vecs[v].en, vecs[v].dv, vecs[v].b, vecs[v].rdy);
      check_outs($sformatf("vec%0d", v), vecs[v].e_recv, vecs[v].e_valid, vecs[v].e_cnt,
                 vecs[v].e_to, vecs[v].e_drop);
      if (vecs[v].chk_w) expect_v($sformatf("vec%0d.word", v), o_Word, vecs[v].e_word);
    end

    // Bytes spaced 20 clocks, then a 50-clock hold without ready.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_v("spaced.receive_on", {31'd0, o_receive}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'h4433_2211 >> (8 * i);
      cyc(1'b0, 1'b1, 1'b1, w[7:0], 1'b0);
      if (i < 3) begin
        expect_v($sformatf("spaced.count%0d", i), {28'd0, o_Byte_Count}, 32'(i + 1));
        for (int j = 0; j < 19; j++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_v($sformatf("spaced.count_hold%0d", i), {28'd0, o_Byte_Count}, 32'(i + 1));
      end
    end
    check_outs("spaced.done", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    expect_v("spaced.word", o_Word, 32'h4433_2211);
    for (int j = 0; j < 50; j++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      expect_v("hold.word", o_Word, 32'h4433_2211);
      expect_v("hold.valid", {31'd0, o_Word_Valid}, 32'd1);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check_outs("hold.release", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Two bytes then silence: timeout exactly 100 clocks after the second byte.
    cyc(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'hBB, 1'b0);
    for (int n = 1; n <= 100; n++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      if (n < 100) begin
        if (o_Timeout !== 1'b0 || o_Byte_Count !== 4'd2)
          expect_v($sformatf("tmo.early%0d", n), {27'd0, o_Timeout, o_Byte_Count}, {27'd0, 1'b0, 4'd2});
      end else begin
        check_outs("tmo.pulse", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_v("tmo.one_cycle", {31'd0, o_Timeout}, 32'd0);
    feed_word("tmo.next_word", 32'h0403_0201);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_v("tmo.release", {31'd0, o_Word_Valid}, 32'd0);

    // Byte arriving in the terminal counter cycle is accepted.
    cyc(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
    for (int n = 1; n <= 99; n++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      if (o_Timeout !== 1'b0) expect_v($sformatf("term.early%0d", n), {31'd0, o_Timeout}, 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'hBB, 1'b0);
    check_outs("term.accept", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_v("term.no_late_tmo", {31'd0, o_Timeout}, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'hCC, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'hDD, 1'b0);
    expect_v("term.word", o_Word, 32'hDDCC_BBAA);
    expect_v("term.valid", {31'd0, o_Word_Valid}, 32'd1);

    // Reset while a word is pending.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    feed_word("rst.fill", 32'hEFBE_ADDE);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check_outs("rst.hold", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_v("rst.word", o_Word, 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_outs("rst.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
